fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage of the multicycle core, directly upstream of the instruction memory.
- Holds the PC and drives the memory's byte address and read enable.
- Captures the combinational 32-bit read data into an instruction register (IR) and presents it to the control unit with a valid/ack handshake.
- Also provides branch/jump PC redirect, a misaligned-PC fault and a fetch counter.

Parameters:
- WIDTH, 32, instruction/data width in bits.
- DEPTH, 16, address width in bits; byte-addressed; matches the instruction memory's addr width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- fetch_req  input  1  control unit requests the next instruction.
- instr_ack  input  1  control unit has consumed the IR contents.
- pc_load  input  1  redirect the PC to pc_target.
- pc_target  input  DEPTH  redirect address.
- mem_data  input  WIDTH  read data from instruction memory; high-Z when not read.
- mem_addr  output  DEPTH  byte address to memory; equals pc.
- mem_rd  output  1  memory read enable.
- ir  output  WIDTH  latched instruction.
- ir_pc  output  DEPTH  address the IR contents were fetched from.
- pc  output  DEPTH  current PC.
- instr_valid  output  1  IR holds a fresh, unacknowledged instruction.
- busy  output  1  state is FETCH.
- fault  output  1  misaligned fetch attempted; sticky.
- fetch_cnt  output  32  count of completed captures.

Behaviour:
- Reset (async, immediate): state=IDLE, pc=RESET_PC, ir=0, ir_pc=0, fetch_cnt=0, fault=0. Outputs: mem_rd=0, instr_valid=0, busy=0.
- Always: mem_addr=pc (combinational). mem_rd=1 only in FETCH. instr_valid=1 only in HOLD. fault=1 only in FAULT.
- IDLE:
  - pc_load: pc<=pc_target; stay IDLE. pc_load takes priority over fetch_req in the same cycle; the fetch_req is ignored.
  - Else fetch_req with pc[1:0]==0: go to FETCH.
  - Else fetch_req with pc[1:0]!=0: go to FAULT.
- FETCH (exactly one cycle): mem_rd=1. At the clock edge:
  - pc_load: discard mem_data, pc<=pc_target, go to IDLE; ir/ir_pc/fetch_cnt unchanged.
  - Otherwise: ir<=mem_data, ir_pc<=pc, pc<=pc+4 (modulo 2^DEPTH; 0xFFFC wraps to 0x0000), fetch_cnt<=fetch_cnt+1 (wraps), go to HOLD.
- HOLD: ir and ir_pc stable.
  - pc_load: pc<=pc_target; stay in HOLD. This is the branch-resolve case; the IR stays valid.
  - instr_ack and fetch_req, pc aligned (after any same-cycle pc_load is applied, i.e. pc_target): go to FETCH back-to-back.
  - instr_ack and fetch_req, that pc misaligned: go to FAULT.
  - instr_ack alone: go to IDLE.
  - No ack: stay in HOLD indefinitely.
- FAULT: mem_rd=0. Only pc_load exits: pc<=pc_target, go to IDLE. fetch_req and instr_ack are ignored.
- Latency: fetch_req sampled in IDLE at edge n → mem_rd=1 during cycle n+1 → instr_valid=1 from cycle n+2. Back-to-back sustained rate is one instruction per 2 cycles.
- mem_data is sampled only at the FETCH-exit edge. A high-Z/X value outside FETCH must never propagate into ir.
- instr_ack outside HOLD has no effect.

Test Plan:
- Reset with RESET_PC=0, memory words 0x00000013@0 and 0x00A00093@4; fetch_req pulse → mem_rd=1 one cycle with mem_addr=0; next cycle instr_valid=1, ir=0x00000013, ir_pc=0, pc=4, fetch_cnt=1.
- Hold fetch_req=1 and instr_ack=1 continuously for 4 instructions → captures at addresses 0,4,8,C on alternate cycles; fetch_cnt=4; pc=0x10.
- In HOLD, pc_load with pc_target=0x0040, plus ack+fetch_req the same cycle → next FETCH uses mem_addr=0x0040; ir_pc=0x0040 after capture.
- pc_load=1 (target 0x0100) during FETCH → ir unchanged, fetch_cnt unchanged, state IDLE, pc=0x0100.
- pc_load target 0x0006, then fetch_req → fault=1, mem_rd stays 0, fetch_req ignored; pc_load 0x0008 → fault=0, IDLE; next fetch reads 0x0008.
- pc=0xFFFC fetch → pc wraps to 0x0000. Assert rst mid-HOLD → outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_if.sv
// Handshake and memory-side bundle between the fetch stage, the control unit
// and the instruction memory.
interface fetch_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
  logic             fetch_req;
  logic             instr_ack;
  logic             pc_load;
  logic [DEPTH-1:0] pc_target;
  logic [WIDTH-1:0] mem_data;
  logic [DEPTH-1:0] mem_addr;
  logic             mem_rd;
  logic [WIDTH-1:0] ir;
  logic [DEPTH-1:0] ir_pc;
  logic [DEPTH-1:0] pc;
  logic             instr_valid;
  logic             busy;
  logic             fault;
  logic [31:0]      fetch_cnt;

  // Environment side: control unit plus instruction memory.
  modport master (
    output fetch_req, instr_ack, pc_load, pc_target, mem_data,
    input  mem_addr, mem_rd, ir, ir_pc, pc, instr_valid, busy, fault, fetch_cnt
  );

  modport slave (
    input  fetch_req, instr_ack, pc_load, pc_target, mem_data,
    output mem_addr, mem_rd, ir, ir_pc, pc, instr_valid, busy, fault, fetch_cnt
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads one word per FETCH cycle into the
// IR and hands it to the control unit with a valid/ack handshake.
module fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 16,
    parameter logic [DEPTH-1:0] RESET_PC = '0
) (
  input logic     clk,
  input logic     rst,
  fetch_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2, FAULT = 2'd3} state_t;

  localparam logic [DEPTH-1:0] PC_STEP = DEPTH'(4);

  state_t           state_r, state_s;
  logic [DEPTH-1:0] pc_r, pc_s;
  logic [WIDTH-1:0] ir_r;
  logic [DEPTH-1:0] ir_pc_r;
  logic [31:0]      fetch_cnt_r;
  logic             capture_s;
  logic [DEPTH-1:0] next_fetch_pc_s;

  // Next-state and PC selection.
  always_comb begin
    state_s         = state_r;
    pc_s            = pc_r;
    capture_s       = 1'b0;
    // A same-cycle redirect decides where the back-to-back fetch from HOLD goes.
    if (bus.pc_load) begin
      next_fetch_pc_s = bus.pc_target;
    end else begin
      next_fetch_pc_s = pc_r;
    end
    case (state_r)
      IDLE: begin
        if (bus.pc_load) begin
          pc_s = bus.pc_target;
        end else if (bus.fetch_req) begin
          state_s = (pc_r[1:0] == 2'b00) ? FETCH : FAULT;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        if (bus.pc_load) begin
          pc_s    = bus.pc_target;
          state_s = IDLE;
        end else begin
          capture_s = 1'b1;
          pc_s      = pc_r + PC_STEP;
          state_s   = HOLD;
        end
      end
      HOLD: begin
        pc_s = next_fetch_pc_s;
        if (bus.instr_ack && bus.fetch_req) begin
          state_s = (next_fetch_pc_s[1:0] == 2'b00) ? FETCH : FAULT;
        end else if (bus.instr_ack) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      FAULT: begin
        if (bus.pc_load) begin
          pc_s    = bus.pc_target;
          state_s = IDLE;
        end else begin
          state_s = FAULT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, PC, IR and fetch counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      pc_r        <= RESET_PC;
      ir_r        <= {WIDTH{1'b0}};
      ir_pc_r     <= {DEPTH{1'b0}};
      fetch_cnt_r <= 32'd0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      // mem_data is only looked at here, so a floating bus never reaches the IR.
      if (capture_s) begin
        ir_r        <= bus.mem_data;
        ir_pc_r     <= pc_r;
        fetch_cnt_r <= fetch_cnt_r + 32'd1;
      end else begin
        ir_r        <= ir_r;
        ir_pc_r     <= ir_pc_r;
        fetch_cnt_r <= fetch_cnt_r;
      end
    end
  end

  assign bus.mem_addr    = pc_r;
  assign bus.pc          = pc_r;
  assign bus.ir          = ir_r;
  assign bus.ir_pc       = ir_pc_r;
  assign bus.fetch_cnt   = fetch_cnt_r;
  assign bus.mem_rd      = (state_r == FETCH);
  assign bus.busy        = (state_r == FETCH);
  assign bus.instr_valid = (state_r == HOLD);
  assign bus.fault       = (state_r == FAULT);

endmodule
